// File: rtl/vcm_pkg.sv
// Shared types and defaults for the VCM driver I2C write transmitter.
package vcm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_BIT   = 3'd2,
    ST_ACK   = 3'd3,
    ST_STOP  = 3'd4
  } state_t;

  localparam logic [1:0] PH_0 = 2'd0;
  localparam logic [1:0] PH_1 = 2'd1;
  localparam logic [1:0] PH_2 = 2'd2;
  localparam logic [1:0] PH_3 = 2'd3;

  localparam int         DEF_CLK_DIV  = 125;
  localparam logic [7:0] DEF_DEV_ADDR = 8'h18;

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-bit tick divider; runs only while enabled and restarts from zero when disabled.
module i2c_tick_gen
  import vcm_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic CLK,
  input  logic RESET,
  input  logic en,
  output logic tick
);

  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_r;

  // Divider counter, held at zero while idle so the first tick is a full period away.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_r <= '0;
    end else if (!en || (cnt_r == LAST)) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + 1'b1;
    end
  end

  assign tick = en && (cnt_r == LAST);

endmodule

// File: rtl/vcm_i2c_tx.sv
// I2C write-only master sending {DEV_ADDR, VCM_DATA[15:8], VCM_DATA[7:0]} to a VCM driver.
module vcm_i2c_tx
  import vcm_pkg::*;
#(
  parameter int         CLK_DIV  = DEF_CLK_DIV,
  parameter logic [7:0] DEV_ADDR = DEF_DEV_ADDR
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] VCM_DATA,
  input  logic        GO,
  input  logic        AUTO_EN,
  output logic        BUSY,
  output logic        DONE,
  output logic        ACK_ERR,
  output logic        I2C_SCL,
  output logic        I2C_SDA_OE,
  input  logic        I2C_SDA_IN
);

  state_t      state_r;
  logic [1:0]  phase_r;
  logic [2:0]  bit_cnt_r;
  logic [1:0]  byte_cnt_r;
  logic [15:0] tx_reg_r;
  logic [15:0] sent_reg_r;
  logic [7:0]  shift_r;
  logic        scl_r;
  logic        sda_oe_r;
  logic        busy_r;
  logic        done_r;
  logic        ack_err_r;
  logic        tick_s;
  logic        start_s;
  logic [7:0]  next_byte_s;

  // Start request and the data byte that follows the current ACK slot.
  always_comb begin
    start_s     = 1'b0;
    next_byte_s = tx_reg_r[7:0];
    if (state_r == ST_IDLE) begin
      start_s = GO || (AUTO_EN && (VCM_DATA != sent_reg_r));
    end else begin
      start_s = 1'b0;
    end
    if (byte_cnt_r == 2'd0) begin
      next_byte_s = tx_reg_r[15:8];
    end else begin
      next_byte_s = tx_reg_r[7:0];
    end
  end

  i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .CLK   (CLK),
    .RESET (RESET),
    .en    (busy_r),
    .tick  (tick_s)
  );

  // Frame sequencer; every tick ends the current quarter-bit phase and sets the next one's bus levels.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r    <= ST_IDLE;
      phase_r    <= PH_0;
      bit_cnt_r  <= 3'd0;
      byte_cnt_r <= 2'd0;
      tx_reg_r   <= 16'h0000;
      sent_reg_r <= 16'h0000;
      shift_r    <= 8'h00;
      scl_r      <= 1'b1;
      sda_oe_r   <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      ack_err_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if ((state_r != ST_IDLE) && tick_s) begin
        phase_r <= phase_r + 2'd1;
      end
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            tx_reg_r  <= VCM_DATA;
            ack_err_r <= 1'b0;
            busy_r    <= 1'b1;
            phase_r   <= PH_0;
            scl_r     <= 1'b1;
            sda_oe_r  <= 1'b0;
            state_r   <= ST_START;
          end
        end
        ST_START: begin
          if (tick_s) begin
            case (phase_r)
              PH_0: sda_oe_r <= 1'b1;
              PH_1: scl_r    <= 1'b0;
              PH_3: begin
                state_r    <= ST_BIT;
                shift_r    <= DEV_ADDR;
                bit_cnt_r  <= 3'd7;
                byte_cnt_r <= 2'd0;
                sda_oe_r   <= ~DEV_ADDR[7];
              end
              default: ;
            endcase
          end
        end
        ST_BIT: begin
          if (tick_s) begin
            case (phase_r)
              PH_0: scl_r <= 1'b1;
              PH_2: scl_r <= 1'b0;
              PH_3: begin
                if (bit_cnt_r == 3'd0) begin
                  state_r  <= ST_ACK;
                  sda_oe_r <= 1'b0;
                end else begin
                  bit_cnt_r <= bit_cnt_r - 3'd1;
                  shift_r   <= {shift_r[6:0], 1'b0};
                  sda_oe_r  <= ~shift_r[6];
                end
              end
              default: ;
            endcase
          end
        end
        ST_ACK: begin
          if (tick_s) begin
            case (phase_r)
              PH_0: scl_r <= 1'b1;
              PH_2: begin
                scl_r <= 1'b0;
                if (I2C_SDA_IN) begin
                  ack_err_r <= 1'b1;
                end
              end
              PH_3: begin
                // A NACK skips any remaining bytes and closes the frame.
                if (ack_err_r || (byte_cnt_r == 2'd2)) begin
                  state_r  <= ST_STOP;
                  sda_oe_r <= 1'b1;
                end else begin
                  state_r    <= ST_BIT;
                  byte_cnt_r <= byte_cnt_r + 2'd1;
                  shift_r    <= next_byte_s;
                  bit_cnt_r  <= 3'd7;
                  sda_oe_r   <= ~next_byte_s[7];
                end
              end
              default: ;
            endcase
          end
        end
        ST_STOP: begin
          if (tick_s) begin
            case (phase_r)
              PH_0: scl_r    <= 1'b1;
              PH_1: sda_oe_r <= 1'b0;
              PH_3: begin
                state_r <= ST_IDLE;
                busy_r  <= 1'b0;
                done_r  <= 1'b1;
                if (!ack_err_r) begin
                  sent_reg_r <= tx_reg_r;
                end
              end
              default: ;
            endcase
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          busy_r   <= 1'b0;
          scl_r    <= 1'b1;
          sda_oe_r <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY       = busy_r;
  assign DONE       = done_r;
  assign ACK_ERR    = ack_err_r;
  assign I2C_SCL    = scl_r;
  assign I2C_SDA_OE = sda_oe_r;

endmodule

// File: tb/tb_vcm_i2c_tx.sv
// Directed plus randomized bench for vcm_i2c_tx with an I2C slave/bus monitor and a frame-level reference model.
module tb_vcm_i2c_tx;

  localparam int         CLK_DIV  = 4;
  localparam logic [7:0] DEV_ADDR = 8'h18;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [15:0] VCM_DATA;
  logic        GO;
  logic        AUTO_EN;
  logic        BUSY;
  logic        DONE;
  logic        ACK_ERR;
  logic        I2C_SCL;
  logic        I2C_SDA_OE;
  logic        I2C_SDA_IN;

  int          compared   = 0;
  int          mismatched = 0;
  int          viol       = 0;
  int          nack_slot  = 0;
  logic        slave_pull = 1'b0;
  logic [15:0] model_sent;

  logic [31:0] mon_bits_q[$];
  int          mon_len_q[$];
  logic [31:0] sr;
  int          len;
  int          idx;
  bit          in_frame = 1'b0;
  logic        p_scl = 1'b1;
  logic        p_sda = 1'b1;

  vcm_i2c_tx #(.CLK_DIV(CLK_DIV), .DEV_ADDR(DEV_ADDR)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .VCM_DATA   (VCM_DATA),
    .GO         (GO),
    .AUTO_EN    (AUTO_EN),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .ACK_ERR    (ACK_ERR),
    .I2C_SCL    (I2C_SCL),
    .I2C_SDA_OE (I2C_SDA_OE),
    .I2C_SDA_IN (I2C_SDA_IN)
  );

  always #5 CLK = ~CLK;

  assign I2C_SDA_IN = ~(I2C_SDA_OE | slave_pull);

  // Bus monitor and ACKing slave: decodes START/STOP, captures bits on SCL rise, flags illegal SDA edges.
  always @(negedge CLK) begin
    if (RESET) begin
      in_frame   = 1'b0;
      slave_pull = 1'b0;
      idx        = 0;
      sr         = 32'd0;
      len        = 0;
    end else begin
      if ((I2C_SCL != p_scl) && (I2C_SDA_IN != p_sda)) begin
        viol++;
      end else if (I2C_SCL && p_scl && (I2C_SDA_IN != p_sda)) begin
        if (!I2C_SDA_IN) begin
          if (in_frame) viol++;
          in_frame = 1'b1;
          idx      = -1;
          sr       = 32'd0;
          len      = 0;
        end else begin
          if (!in_frame) begin
            viol++;
          end else begin
            mon_bits_q.push_back(sr >> 1);
            mon_len_q.push_back(len - 1);
          end
          in_frame = 1'b0;
        end
      end
      if (in_frame && I2C_SCL && !p_scl) begin
        sr = {sr[30:0], I2C_SDA_IN};
        len++;
      end
      if (in_frame && !I2C_SCL && p_scl) begin
        idx++;
        slave_pull = ((idx == 8) && (nack_slot != 1)) || ((idx == 17) && (nack_slot != 2)) ||
                     ((idx == 26) && (nack_slot != 3));
      end
    end
    p_scl = I2C_SCL;
    p_sda = ~(I2C_SDA_OE | slave_pull);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp_v);
    end
  endtask

  // Expected bus bits: each byte MSB first followed by its ACK bit; a NACKed slot ends the frame.
  task automatic exp_frame(input logic [15:0] d, input int ns, output logic [31:0] b, output int l);
    logic [7:0] byt;
    int         slots;
    slots = (ns == 0) ? 3 : ns;
    b = 32'd0;
    l = 0;
    for (int s = 0; s < slots; s++) begin
      byt = (s == 0) ? DEV_ADDR : ((s == 1) ? d[15:8] : d[7:0]);
      for (int i = 7; i >= 0; i--) b = {b[30:0], byt[i]};
      b = {b[30:0], (s == ns - 1)};
      l += 9;
    end
  endtask

  function automatic logic [15:0] rnd_word();
    logic [9:0] step;
    step = 10'($urandom());
    return {2'b00, step, 4'b1111};
  endfunction

  // Called on the negedge right after the accepting edge; ends on the negedge after DONE.
  task automatic check_frame(input logic [15:0] d, input int ns, input bit disturb);
    logic [31:0] eb;
    logic [31:0] mb;
    int          el;
    int          ml;
    int          n;
    int          slots;
    chk1("busy_rise", BUSY, 1'b1);
    chk1("ack_err_clear", ACK_ERR, 1'b0);
    exp_frame(d, ns, eb, el);
    slots = (ns == 0) ? 3 : ns;
    n = 0;
    while ((DONE !== 1'b1) && (n < 3000)) begin
      if (disturb && (n == 100)) begin
        GO       = 1'b1;
        VCM_DATA = ~d;
      end
      if (disturb && (n == 101)) begin
        GO       = 1'b0;
        VCM_DATA = d;
      end
      @(negedge CLK);
      n++;
    end
    chk("done_latency", n, (8 + 36 * slots) * CLK_DIV);
    chk1("busy_fall", BUSY, 1'b0);
    chk1("ack_err", ACK_ERR, ns != 0);
    chk("frame_count", mon_len_q.size(), 1);
    if (mon_len_q.size() > 0) begin
      ml = mon_len_q.pop_front();
      mb = mon_bits_q.pop_front();
      chk("frame_len", ml, el);
      chk("frame_bits", mb, eb);
    end
    if (ns == 0) model_sent = d;
    @(negedge CLK);
    chk1("done_pulse", DONE, 1'b0);
  endtask

  task automatic expect_idle(input int cyc);
    int b;
    b = 0;
    repeat (cyc) begin
      @(negedge CLK);
      if (BUSY) b++;
    end
    chk("idle_busy", b, 0);
    chk("idle_frames", mon_len_q.size(), 0);
  endtask

  task automatic send_go(input logic [15:0] d, input int ns, input bit disturb);
    @(negedge CLK);
    VCM_DATA = d;
    GO       = 1'b1;
    @(negedge CLK);
    GO = 1'b0;
    check_frame(d, ns, disturb);
  endtask

  task automatic auto_set(input logic [15:0] d);
    @(negedge CLK);
    VCM_DATA = d;
    @(negedge CLK);
    if (d != model_sent) check_frame(d, nack_slot, 1'b0);
    else expect_idle(100);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    logic [15:0] prev;
    RESET      = 1'b1;
    GO         = 1'b0;
    AUTO_EN    = 1'b0;
    VCM_DATA   = 16'h0000;
    model_sent = 16'h0000;
    repeat (3) @(negedge CLK);
    chk1("rst_scl", I2C_SCL, 1'b1);
    chk1("rst_sda_oe", I2C_SDA_OE, 1'b0);
    chk1("rst_busy", BUSY, 1'b0);
    chk1("rst_done", DONE, 1'b0);
    chk1("rst_ack_err", ACK_ERR, 1'b0);
    RESET = 1'b0;

    send_go(16'h200F, 0, 1'b0);

    nack_slot = 1;
    send_go(rnd_word(), 1, 1'b0);
    nack_slot = 0;
    expect_idle(20);
    chk1("ack_err_sticky", ACK_ERR, 1'b1);

    nack_slot = $urandom_range(2, 3);
    send_go(rnd_word(), nack_slot, 1'b0);
    nack_slot = 0;

    send_go(rnd_word(), 0, 1'b1);
    expect_idle(60);

    AUTO_EN = 1'b1;
    expect_idle(50);
    auto_set(16'h200F);
    expect_idle(200);
    auto_set(16'h201F);
    expect_idle(100);

    nack_slot = 2;
    d = rnd_word();
    auto_set(d);
    nack_slot = 0;
    check_frame(d, 0, 1'b0);
    expect_idle(100);

    prev = model_sent;
    for (int k = 0; k < 6; k++) begin
      d = ($urandom_range(0, 1) == 0) ? prev : rnd_word();
      auto_set(d);
      prev = d;
    end

    d = rnd_word();
    while (d == model_sent) d = rnd_word();
    @(negedge CLK);
    VCM_DATA = d;
    GO       = 1'b1;
    @(negedge CLK);
    GO = 1'b0;
    check_frame(d, 0, 1'b0);
    expect_idle(100);
    AUTO_EN = 1'b0;

    // Abort at tick 50: SCL is high there and the sent bit (TX_REG[13]) is forced to 0.
    d = rnd_word();
    d[13] = 1'b0;
    @(negedge CLK);
    VCM_DATA = d;
    GO       = 1'b1;
    @(negedge CLK);
    GO = 1'b0;
    repeat (50 * CLK_DIV - 1) @(posedge CLK);
    #1;
    chk1("pre_rst_scl", I2C_SCL, 1'b1);
    chk1("pre_rst_sda_oe", I2C_SDA_OE, 1'b1);
    RESET = 1'b1;
    #1;
    chk1("async_rst_scl", I2C_SCL, 1'b1);
    chk1("async_rst_sda_oe", I2C_SDA_OE, 1'b0);
    chk1("async_rst_busy", BUSY, 1'b0);
    chk1("async_rst_done", DONE, 1'b0);
    chk1("async_rst_ack_err", ACK_ERR, 1'b0);
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    model_sent = 16'h0000;
    chk("aborted_frames", mon_len_q.size(), 0);

    VCM_DATA = 16'h0000;
    AUTO_EN  = 1'b1;
    expect_idle(50);
    AUTO_EN = 1'b0;
    send_go(rnd_word(), 0, 1'b0);

    chk("bus_protocol", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/vcm_i2c_tx.md
VCM_I2C_TX -- requirements
Module: vcm_i2c_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 125, CLK cycles per quarter SCL bit (100 kHz SCL at 50 MHz).
REQ-002 SHALL have parameter DEV_ADDR, default 8'h18, 8-bit write address byte of the VCM driver.
REQ-003 SHALL have port CLK  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port RESET  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port VCM_DATA  in  16  word to send, format {2'b00, step[9:0], 4'b1111}.
REQ-006 SHALL have port GO  in  1  single-cycle send request.
REQ-007 SHALL have port AUTO_EN  in  1  high = send automatically whenever VCM_DATA differs from last sent word.
REQ-008 SHALL have port BUSY  out  1  transaction in progress.
REQ-009 SHALL have port DONE  out  1  one-cycle pulse at transaction end.
REQ-010 SHALL have port ACK_ERR  out  1  sticky NACK flag for the last transaction.
REQ-011 SHALL have port I2C_SCL  out  1  SCL, push-pull.
REQ-012 SHALL have port I2C_SDA_OE  out  1  1 = drive SDA low; 0 = release (open-drain).
REQ-013 SHALL have port I2C_SDA_IN  in  1  SDA pin sampled value.

Function
REQ-014 States: IDLE, START, BIT, ACK, STOP; a tick is one pulse every CLK_DIV cycles, counted only while BUSY.
REQ-015 IDLE: start when GO=1, or when AUTO_EN=1 and VCM_DATA != SENT_REG; VCM_DATA is latched into TX_REG that cycle; BUSY rises next cycle.
REQ-016 GO while BUSY SHALL be ignored; VCM_DATA changes while BUSY SHALL not affect the frame in flight.
REQ-017 Frame: START, DEV_ADDR, ACK, TX_REG[15:8], ACK, TX_REG[7:0], ACK, STOP; bytes MSB first.
REQ-018 START (4 ticks): SDA released/SCL high, then SDA low with SCL high, then SCL low.
REQ-019 Each data/ACK bit (4 ticks): phase0 SCL low and SDA updated; phase1 SCL high; phase2 SCL high and I2C_SDA_IN sampled; phase3 SCL low.
REQ-020 ACK slot: SDA released; sampled 1 SHALL set ACK_ERR and go directly to STOP.
REQ-021 STOP (4 ticks): SDA low with SCL low, SCL high, SDA released, hold.
REQ-022 Full ACKed frame SHALL last exactly 116 ticks (4+108+4); BUSY SHALL fall and DONE pulse in the same cycle.
REQ-023 On DONE with no NACK, SENT_REG <= TX_REG; on NACK, SENT_REG unchanged, so AUTO_EN retries.
REQ-024 ACK_ERR SHALL clear when the next transaction is accepted.
REQ-025 SDA SHALL change only while SCL is low, except for START and STOP.
REQ-026 GO and an AUTO_EN trigger in the same cycle SHALL start exactly one transaction.
REQ-027 At least one full tick SHALL separate DONE from the next START.

Reset
REQ-028 RESET SHALL asynchronously force IDLE, I2C_SCL=1, I2C_SDA_OE=0, BUSY=0, DONE=0, ACK_ERR=0, tick counter=0, bit counter=0.
REQ-029 RESET SHALL also force TX_REG=0 and SENT_REG=0.
REQ-030 RESET mid-frame SHALL abort without a STOP; the bus is released immediately.

Structure
REQ-031 Package vcm_pkg SHALL hold the state enum, the phase constants, and the default DEV_ADDR and CLK_DIV values.
REQ-032 Sub-module i2c_tick_gen (CLK_DIV divider producing a tick, enabled by BUSY) SHALL be instantiated once.

Verification (CLK_DIV=4; slave model ACKs unless stated)
REQ-033 GO with VCM_DATA=16'h200F -> bytes 18,20,0F on SDA; DONE after 464 cycles; ACK_ERR=0.
REQ-034 Slave NACKs address -> ACK_ERR=1; STOP follows the first ACK slot; DONE pulses; no data bytes sent.
REQ-035 AUTO_EN=1 and VCM_DATA 16'h200F->16'h201F -> exactly one frame per change; no frame when unchanged.
REQ-036 GO repeated mid-frame, and VCM_DATA changed mid-frame -> frame unaltered; only one DONE.
REQ-037 RESET asserted at tick 50 -> SCL=1 and SDA_OE=0 asynchronously; BUSY=0; next GO yields a correct frame.
REQ-038 Bus monitor throughout -> no SDA edge while SCL high except START and STOP.
